// File: rtl/upl_udp_echo.sv
// upl_udp_echo: store-and-forward UDP echo between the UPL receive and send
// streams. One packet is buffered, its IP addresses and UDP ports are swapped
// and it is retransmitted. Packets larger than the buffer are dropped and counted.
module upl_udp_echo #(
    parameter int ADDR_W = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] UPL_input_data,
    input  logic        UPL_input_en,
    input  logic        UPL_input_req,
    output logic        UPL_input_ack,
    output logic [31:0] UPL_output_data,
    output logic        UPL_output_en,
    output logic        UPL_output_req,
    input  logic        UPL_output_ack,
    output logic [15:0] echo_count,
    output logic [15:0] drop_count
);
    // Handshake: an input word is taken on every cycle UPL_input_en is high
    // (the packet ends on the first low cycle); upstream is only throttled by
    // withholding UPL_input_ack between packets. On the send side the packet
    // is requested with UPL_output_req and streamed with UPL_output_en high for
    // every word, without gaps, once UPL_output_ack has been sampled high.

    localparam logic [ADDR_W:0] FULL      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MIN_WORDS = (ADDR_W + 1)'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN,
        S_SEND_REQ,
        S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;      // words stored for current packet
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;  // buffer reads issued in SEND
    logic              rd_valid_q, rd_valid_d;
    logic              rd_swap_q, rd_swap_d; // read word is the port word
    logic              wait_low_q, wait_low_d;
    logic              ack_q, ack_d;
    logic              req_q, req_d;
    logic              out_en_q, out_en_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [15:0]       echo_q, echo_d;
    logic [15:0]       drop_q, drop_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [1 << ADDR_W];

    // Next-state, buffer control and counter updates.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = 1'b0;
        rd_swap_d  = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = wcnt_q[ADDR_W-1:0];
        echo_d     = echo_q;
        drop_d     = drop_q;
        ack_d      = 1'b0;
        // After reset, words of an interrupted packet are ignored until a gap.
        wait_low_d = wait_low_q & UPL_input_en;

        unique case (state_q)
            S_IDLE: begin
                rd_cnt_d = '0;
                if (UPL_input_en && !wait_low_q) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wcnt_d  = (ADDR_W + 1)'(1);
                    state_d = S_RECV;
                end else begin
                    ack_d = UPL_input_req;
                end
            end
            S_RECV: begin
                if (UPL_input_en) begin
                    if (wcnt_q == FULL) begin
                        state_d = S_DRAIN;
                    end else begin
                        wr_en  = 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else if (wcnt_q >= MIN_WORDS) begin
                    state_d = S_SEND_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!UPL_input_en) begin
                    drop_d  = drop_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            S_SEND_REQ: begin
                rd_cnt_d = '0;
                if (UPL_output_ack) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (rd_cnt_q != wcnt_q) begin
                    // Reading w1 first and w0 second swaps the IP addresses.
                    if (rd_cnt_q == '0) begin
                        rd_addr = ADDR_W'(1);
                    end else if (rd_cnt_q == (ADDR_W + 1)'(1)) begin
                        rd_addr = '0;
                    end else begin
                        rd_addr = rd_cnt_q[ADDR_W-1:0];
                    end
                    rd_valid_d = 1'b1;
                    rd_swap_d  = (rd_cnt_q == (ADDR_W + 1)'(2));
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                end else if (rd_valid_q) begin
                    // Last word is being loaded into the output register.
                    echo_d  = echo_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d      = (state_d == S_SEND_REQ);
        out_en_d   = rd_valid_q;
        out_data_d = 32'h0;
        if (rd_valid_q) begin
            out_data_d = rd_swap_q ? {rdata_q[15:0], rdata_q[31:16]} : rdata_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_swap_q  <= 1'b0;
            wait_low_q <= 1'b1;
            ack_q      <= 1'b0;
            req_q      <= 1'b0;
            out_en_q   <= 1'b0;
            out_data_q <= 32'h0;
            echo_q     <= 16'h0;
            drop_q     <= 16'h0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_swap_q  <= rd_swap_d;
            wait_low_q <= wait_low_d;
            ack_q      <= ack_d;
            req_q      <= req_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
            echo_q     <= echo_d;
            drop_q     <= drop_d;
        end
    end

    // Packet buffer: synchronous write, synchronous read with one cycle latency.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= UPL_input_data;
        end
        rdata_q <= mem[rd_addr];
    end

    assign UPL_input_ack   = ack_q;
    assign UPL_output_req  = req_q;
    assign UPL_output_en   = out_en_q;
    assign UPL_output_data = out_data_q;
    assign echo_count      = echo_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_upl_udp_echo.sv
// Bench for upl_udp_echo with a 16-word buffer. Packets are generated randomly
// (plus fixed vectors), a reference model derives the echoed words, and a
// negedge monitor compares the send stream against the expected queue.
module tb_upl_udp_echo;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk;
    logic        reset_n;
    logic [31:0] UPL_input_data;
    logic        UPL_input_en;
    logic        UPL_input_req;
    logic        UPL_input_ack;
    logic [31:0] UPL_output_data;
    logic        UPL_output_en;
    logic        UPL_output_req;
    logic        UPL_output_ack;
    logic [15:0] echo_count;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run_len  = 0;
    int first_out_cyc = 0;
    int req_cycles = 0;

    logic [31:0] pkt_q[$];
    logic [31:0] exp_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_w;
    int          exp_len;
    logic [15:0] exp_echo = 16'h0;
    logic [15:0] exp_drop = 16'h0;

    upl_udp_echo #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .UPL_input_data  (UPL_input_data),
        .UPL_input_en    (UPL_input_en),
        .UPL_input_req   (UPL_input_req),
        .UPL_input_ack   (UPL_input_ack),
        .UPL_output_data (UPL_output_data),
        .UPL_output_en   (UPL_output_en),
        .UPL_output_req  (UPL_output_req),
        .UPL_output_ack  (UPL_output_ack),
        .echo_count      (echo_count),
        .drop_count      (drop_count)
    );

    // Clock and cycle stamp.
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every send word is checked against the expected queue and
    // every burst length against the expected packet length.
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else begin
            if (UPL_output_req) req_cycles = req_cycles + 1;
            if (UPL_output_en) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL out_unexpected: got %h, expected no output", UPL_output_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (UPL_output_data !== exp_w) begin
                        failures = failures + 1;
                        $display("FAIL out_word: got %h, expected %h", UPL_output_data, exp_w);
                    end
                end
                if (run_len == 0) first_out_cyc = cyc;
                run_len = run_len + 1;
            end else begin
                checks = checks + 1;
                if (UPL_output_data !== 32'h0) begin
                    failures = failures + 1;
                    $display("FAIL idle_data: got %h, expected 0", UPL_output_data);
                end
                if (run_len != 0) begin
                    checks = checks + 1;
                    if (exp_len_q.size() == 0) begin
                        failures = failures + 1;
                        $display("FAIL burst_len: got burst of %0d, expected none", run_len);
                    end else begin
                        exp_len = exp_len_q.pop_front();
                        if (run_len != exp_len) begin
                            failures = failures + 1;
                            $display("FAIL burst_len: got %0d contiguous words, expected %0d", run_len, exp_len);
                        end
                    end
                    run_len = 0;
                end
            end
        end
    end

    // Build a random packet of n words with a consistent length field.
    task automatic build_pkt(input int n);
        pkt_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 3) pkt_q.push_back(32'((n - 4) * 4));
            else        pkt_q.push_back($urandom());
        end
    endtask

    // Reference model: echoed packet is w1, w0, ports swapped, rest unchanged.
    task automatic model_pkt();
        int n;
        logic [31:0] pw;
        n = pkt_q.size();
        if (n > DEPTH) begin
            exp_drop = exp_drop + 16'd1;
        end else if (n >= 4) begin
            exp_q.push_back(pkt_q[1]);
            exp_q.push_back(pkt_q[0]);
            pw = pkt_q[2];
            exp_q.push_back({pw[15:0], pw[31:16]});
            for (int i = 3; i < n; i++) exp_q.push_back(pkt_q[i]);
            exp_len_q.push_back(n);
            exp_echo = exp_echo + 16'd1;
        end
    endtask

    // Driver: request, wait for grant, stream pkt_q contiguously.
    task automatic drive_pkt();
        int n;
        @(posedge clk); #1;
        UPL_input_req = 1'b1;
        n = 0;
        while (UPL_input_ack !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks = checks + 1;
        if (UPL_input_ack !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL ack_wait: input_ack %b after %0d cycles, expected 1", UPL_input_ack, n);
        end
        foreach (pkt_q[i]) begin
            UPL_input_en   = 1'b1;
            UPL_input_data = pkt_q[i];
            @(posedge clk); #1;
            UPL_input_req  = 1'b0;
        end
        UPL_input_en   = 1'b0;
        UPL_input_data = 32'h0;
    endtask

    // Wait until every expected word has been seen, bounded.
    task automatic wait_out();
        int n;
        repeat (3) @(negedge clk);
        n = 0;
        while ((exp_q.size() != 0 || run_len != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0 || run_len != 0) begin
            failures = failures + 1;
            $display("FAIL echo_timeout: %0d words still outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if ({UPL_input_ack, UPL_output_req, UPL_output_en} !== 3'b000 || UPL_output_data !== 32'h0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs: ack/req/en %b%b%b data %h, expected 000 and 0",
                     UPL_input_ack, UPL_output_req, UPL_output_en, UPL_output_data);
        end
        checks = checks + 1;
        if (echo_count !== 16'h0 || drop_count !== 16'h0) begin
            failures = failures + 1;
            $display("FAIL reset_counts: echo %h drop %h, expected 0 0", echo_count, drop_count);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        UPL_input_req = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (UPL_input_ack !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL ack_latency_early: got %b, expected 0", UPL_input_ack);
        end
        @(negedge clk);
        checks = checks + 1;
        if (UPL_input_ack !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL ack_latency: got %b, expected 1", UPL_input_ack);
        end
        UPL_input_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int req_cyc;
        pkt_q = '{32'h0A000001, 32'h0A000003, 32'hC0004001, 32'h00000008,
                  32'h11223344, 32'h55667788};
        exp_q.push_back(32'h0A000003);
        exp_q.push_back(32'h0A000001);
        exp_q.push_back(32'h4001C000);
        exp_q.push_back(32'h00000008);
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'h55667788);
        exp_len_q.push_back(6);
        exp_echo = exp_echo + 16'd1;
        drive_pkt();
        @(negedge clk);
        checks = checks + 1;
        if (UPL_output_req !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL req_latency_early: got %b, expected 0", UPL_output_req);
        end
        @(negedge clk);
        req_cyc = cyc;
        checks = checks + 1;
        if (UPL_output_req !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL req_latency: got %b, expected 1", UPL_output_req);
        end
        wait_out();
        checks = checks + 1;
        if (first_out_cyc - req_cyc != 3) begin
            failures = failures + 1;
            $display("FAIL first_word_latency: got %0d cycles after req, expected 3", first_out_cyc - req_cyc);
        end
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL basic_echo_count: got %h, expected %h", echo_count, exp_echo);
        end
    endtask

    task automatic test_back_pressure();
        int ack_seen;
        int req_low;
        UPL_output_ack = 1'b0;
        build_pkt(8);
        model_pkt();
        drive_pkt();
        @(posedge clk); #1;
        UPL_input_req = 1'b1;
        ack_seen = 0;
        req_low  = 0;
        repeat (50) begin
            @(negedge clk);
            if (UPL_input_ack !== 1'b0) ack_seen++;
            if (UPL_output_req !== 1'b1) req_low++;
        end
        checks = checks + 1;
        if (ack_seen != 0) begin
            failures = failures + 1;
            $display("FAIL bp_input_ack: ack high %0d cycles while busy, expected 0", ack_seen);
        end
        checks = checks + 1;
        if (req_low != 0) begin
            failures = failures + 1;
            $display("FAIL bp_output_req: req low %0d cycles while waiting, expected 0", req_low);
        end
        UPL_output_ack = 1'b1;
        build_pkt(11);
        drive_pkt();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL bp_order: %0d words of first echo pending at grant, expected 0", exp_q.size());
        end
        model_pkt();
        wait_out();
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL bp_echo_count: got %h, expected %h", echo_count, exp_echo);
        end
    endtask

    task automatic test_full_oversize();
        int req_before;
        build_pkt(DEPTH);
        model_pkt();
        drive_pkt();
        wait_out();
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL full_echo_count: got %h, expected %h", echo_count, exp_echo);
        end
        req_before = req_cycles;
        build_pkt(DEPTH + 1);
        model_pkt();
        drive_pkt();
        repeat (20) @(negedge clk);
        checks = checks + 1;
        if (req_cycles != req_before) begin
            failures = failures + 1;
            $display("FAIL oversize_req: req high %0d cycles, expected 0", req_cycles - req_before);
        end
        checks = checks + 1;
        if (drop_count !== exp_drop || echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL oversize_counts: drop %h echo %h, expected %h %h", drop_count, echo_count, exp_drop, exp_echo);
        end
        build_pkt(6);
        model_pkt();
        drive_pkt();
        wait_out();
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL after_drop_echo_count: got %h, expected %h", echo_count, exp_echo);
        end
    endtask

    task automatic test_runt();
        int req_before;
        req_before = req_cycles;
        build_pkt(3);
        model_pkt();
        drive_pkt();
        repeat (20) @(negedge clk);
        checks = checks + 1;
        if (req_cycles != req_before) begin
            failures = failures + 1;
            $display("FAIL runt_req: req high %0d cycles, expected 0", req_cycles - req_before);
        end
        checks = checks + 1;
        if (echo_count !== exp_echo || drop_count !== exp_drop) begin
            failures = failures + 1;
            $display("FAIL runt_counts: echo %h drop %h, expected %h %h", echo_count, drop_count, exp_echo, exp_drop);
        end
        build_pkt(5);
        model_pkt();
        drive_pkt();
        wait_out();
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL after_runt_echo_count: got %h, expected %h", echo_count, exp_echo);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int req_before;
        build_pkt(20);
        @(posedge clk); #1;
        UPL_input_req = 1'b1;
        n = 0;
        while (UPL_input_ack !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        foreach (pkt_q[i]) begin
            UPL_input_en   = 1'b1;
            UPL_input_data = pkt_q[i];
            if (i == 5) reset_n = 1'b0;
            if (i == 6) reset_n = 1'b1;
            @(posedge clk); #1;
            UPL_input_req = 1'b0;
            if (i == 5) begin
                exp_echo = 16'h0;
                exp_drop = 16'h0;
                checks = checks + 1;
                if ({UPL_input_ack, UPL_output_req, UPL_output_en} !== 3'b000 || UPL_output_data !== 32'h0) begin
                    failures = failures + 1;
                    $display("FAIL midreset_outputs: ack/req/en %b%b%b data %h, expected 000 and 0",
                             UPL_input_ack, UPL_output_req, UPL_output_en, UPL_output_data);
                end
                checks = checks + 1;
                if (echo_count !== exp_echo || drop_count !== exp_drop) begin
                    failures = failures + 1;
                    $display("FAIL midreset_counts: echo %h drop %h, expected 0 0", echo_count, drop_count);
                end
            end
        end
        UPL_input_en   = 1'b0;
        UPL_input_data = 32'h0;
        req_before = req_cycles;
        repeat (30) @(negedge clk);
        checks = checks + 1;
        if (req_cycles != req_before || drop_count !== exp_drop || echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL midreset_trailing: req cycles %0d drop %h echo %h, expected 0 0 0",
                     req_cycles - req_before, drop_count, echo_count);
        end
        build_pkt(7);
        model_pkt();
        drive_pkt();
        wait_out();
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL midreset_echo_count: got %h, expected %h", echo_count, exp_echo);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.echo_q = 16'hFFFF;
        exp_echo   = 16'hFFFF;
        build_pkt(4);
        model_pkt();
        drive_pkt();
        wait_out();
        checks = checks + 1;
        if (echo_count !== exp_echo) begin
            failures = failures + 1;
            $display("FAIL echo_wrap: got %h, expected %h", echo_count, exp_echo);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 14; p++) begin
            UPL_output_ack = 1'($urandom_range(0, 1));
            build_pkt($urandom_range(1, DEPTH + 2));
            model_pkt();
            drive_pkt();
            if (UPL_output_ack == 1'b0) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                UPL_output_ack = 1'b1;
            end
            wait_out();
            checks = checks + 1;
            if (echo_count !== exp_echo || drop_count !== exp_drop) begin
                failures = failures + 1;
                $display("FAIL random_counts pkt %0d: echo %h drop %h, expected %h %h",
                         p, echo_count, drop_count, exp_echo, exp_drop);
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        UPL_input_data = 32'h0;
        UPL_input_en   = 1'b0;
        UPL_input_req  = 1'b0;
        UPL_output_ack = 1'b1;
        test_reset();
        test_basic();
        test_back_pressure();
        test_full_oversize();
        test_runt();
        test_reset_mid();
        test_wrap();
        test_random();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
